// File: rtl/bundle_accumulator.sv
// bundle_accumulator: majority-vote accumulator for hypervector bundling.
// Each beat, every core casts a vote of +1, -1 or 0 (masked). A registered
// pairwise adder tree reduces the votes, and a signed accumulator sums the
// per-beat totals. The sign of the accumulator is the bundled bit.
// Optional feature macro: BUNDLE_SAT_EN (saturating accumulator + sticky sat flag).
// Without it the accumulator wraps modulo 2^W and o_sat is tied low.
// The per-beat sum width S must be smaller than W + 1 (true for W >= 4 with
// reasonable core counts).
module bundle_accumulator #(
  parameter int W       = 30,
  parameter int CORENUM = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_inValid,
  input  logic [CORENUM-1:0] i_voteEn,
  input  logic [CORENUM-1:0] i_voteBit,
  output logic [W-1:0]       o_acc,
  output logic               o_signBit,
  output logic               o_accValid,
  output logic               o_busy,
  output logic               o_sat
);

  localparam int D = (CORENUM > 1) ? $clog2(CORENUM) : 0;
  localparam int S = $clog2(CORENUM + 1) + 1;

  localparam logic signed [S-1:0] VOTE_POS = S'(1);
  localparam logic signed [S-1:0] VOTE_NEG = S'(-1);

  // One valid bit per stage: index 0 is the vote register, 1..D the tree levels.
  logic [D:0]   r_valid;
  logic [W-1:0] r_acc;
  logic         r_accValid;
  logic         r_sat;

  logic         w_flush;
  logic [S-1:0] w_finalSum;
  logic [W:0]   w_sumExt;

  assign w_flush = rst | i_clear;

  // Level l holds ceil(CORENUM / 2^l) partial sums; level 0 holds the raw votes.
  for (genvar l = 0; l <= D; l++) begin : g_level
    localparam int NODES = (CORENUM + (1 << l) - 1) >> l;
    logic [S-1:0] r_node [NODES];

    if (l == 0) begin : g_leaf
      // Translate each core's enable/bit pair into a signed vote.
      always_ff @(posedge clk) begin
        for (int i = 0; i < CORENUM; i++) begin
          if (i_voteEn[i]) begin
            r_node[i] <= i_voteBit[i] ? VOTE_POS : VOTE_NEG;
          end else begin
            r_node[i] <= '0;
          end
        end
      end
    end else begin : g_add
      localparam int PREV = (CORENUM + (1 << (l - 1)) - 1) >> (l - 1);
      logic [S-1:0] w_in [2*NODES];

      // An odd leftover node is paired with zero, which passes it through unchanged.
      for (genvar k = 0; k < 2 * NODES; k++) begin : g_pad
        if (k < PREV) begin : g_real
          assign w_in[k] = g_level[l-1].r_node[k];
        end else begin : g_zero
          assign w_in[k] = '0;
        end
      end

      // Pairwise add of the previous level; width S already covers the full range.
      always_ff @(posedge clk) begin
        for (int j = 0; j < NODES; j++) begin
          r_node[j] <= w_in[2*j] + w_in[2*j+1];
        end
      end
    end
  end

  assign w_finalSum = g_level[D].r_node[0];
  assign w_sumExt   = {{(W + 1 - S){w_finalSum[S-1]}}, w_finalSum};

  // Valid bits advance one stage per cycle; reset or clear drops every beat in flight.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_inValid;
      for (int s = 1; s <= D; s++) begin
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

`ifdef BUNDLE_SAT_EN
  localparam logic [W-1:0] ACC_MAX = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] ACC_MIN = {1'b1, {(W - 1){1'b0}}};

  logic [W:0] w_accNext;
  logic       w_overflow;

  assign w_accNext  = {r_acc[W-1], r_acc} + w_sumExt;
  assign w_overflow = w_accNext[W] ^ w_accNext[W-1];

  // Absorb the tree output; clamp toward the true sign on overflow and latch sat.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_accValid <= 1'b0;
    end else begin
      r_accValid <= r_valid[D];
      if (r_valid[D]) begin
        if (w_overflow) begin
          r_acc <= w_accNext[W] ? ACC_MIN : ACC_MAX;
          r_sat <= 1'b1;
        end else begin
          r_acc <= w_accNext[W-1:0];
        end
      end
    end
  end
`else
  logic [W-1:0] w_accNext;

  assign w_accNext = r_acc + w_sumExt[W-1:0];

  // Absorb the tree output with plain modulo-2^W wraparound.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_acc      <= '0;
      r_accValid <= 1'b0;
    end else begin
      r_accValid <= r_valid[D];
      if (r_valid[D]) begin
        r_acc <= w_accNext;
      end
    end
  end

  assign r_sat = 1'b0;
`endif

  assign o_acc      = r_acc;
  assign o_signBit  = r_acc[W-1];
  assign o_accValid = r_accValid;
  assign o_busy     = |r_valid;
  assign o_sat      = r_sat;

endmodule

// File: tb/tb_bundle_accumulator.sv
// tb_bundle_accumulator: directed self-checking bench for bundle_accumulator
// with CORENUM=4 (three-cycle latency) and W=8. Expected values are computed
// by hand from the vote patterns; the saturation scenario follows BUNDLE_SAT_EN.
module tb_bundle_accumulator;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              inValid;
  logic [3:0]        voteEn;
  logic [3:0]        voteBit;
  logic signed [7:0] acc;
  logic              signBit;
  logic              accValid;
  logic              busy;
  logic              sat;

  int checks;
  int failures;

  bundle_accumulator #(.W(8), .CORENUM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (clear),
    .i_inValid  (inValid),
    .i_voteEn   (voteEn),
    .i_voteBit  (voteBit),
    .o_acc      (acc),
    .o_signBit  (signBit),
    .o_accValid (accValid),
    .o_busy     (busy),
    .o_sat      (sat)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for the next edge.
  task automatic applyStimulus(input logic v, input logic [3:0] en, input logic [3:0] vb);
    inValid = v;
    voteEn  = en;
    voteBit = vb;
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (acc !== 8'sd0) begin failures++; $display("[TB] FAIL reset_acc: got %0d want 0", acc); end
    checks++; if (signBit !== 1'b0) begin failures++; $display("[TB] FAIL reset_sign: got %b want 0", signBit); end
    checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", accValid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sat !== 1'b0) begin failures++; $display("[TB] FAIL reset_sat: got %b want 0", sat); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    applyStimulus(1'b1, 4'b1111, 4'b0111);
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_k: got %b want 1", busy); end
    checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_valid: got %b want 0", accValid); end
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_k1: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_k2: got %b want 1", busy); end
    checks++; if (acc !== 8'sd0) begin failures++; $display("[TB] FAIL single_acc_early: got %0d want 0", acc); end
    tick();
    checks++; if (acc !== 8'sd2) begin failures++; $display("[TB] FAIL single_acc: got %0d want 2", acc); end
    checks++; if (accValid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid: got %b want 1", accValid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_done: got %b want 0", busy); end
    checks++; if (signBit !== 1'b0) begin failures++; $display("[TB] FAIL single_sign: got %b want 0", signBit); end
    tick();
    checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_pulse: got %b want 0", accValid); end
    checks++; if (acc !== 8'sd2) begin failures++; $display("[TB] FAIL single_acc_hold: got %0d want 2", acc); end
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] expAcc [3];
    expAcc[0] = -8'sd4;
    expAcc[1] = -8'sd8;
    expAcc[2] = -8'sd12;
    doClear();
    checks++; if (acc !== 8'sd0) begin failures++; $display("[TB] FAIL b2b_clear: got %0d want 0", acc); end
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (acc !== expAcc[i]) begin failures++; $display("[TB] FAIL b2b_acc%0d: got %0d want %0d", i, acc, expAcc[i]); end
      checks++; if (accValid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid%0d: got %b want 1", i, accValid); end
    end
    checks++; if (signBit !== 1'b1) begin failures++; $display("[TB] FAIL b2b_sign: got %b want 1", signBit); end
    tick();
    checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_valid_end: got %b want 0", accValid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_masked();
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    tick();
    applyStimulus(1'b1, 4'b1010, 4'b1000);
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL masked_early: got %b want 0", accValid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (accValid !== 1'b1) begin failures++; $display("[TB] FAIL masked_valid%0d: got %b want 1", i, accValid); end
      checks++; if (acc !== -8'sd12) begin failures++; $display("[TB] FAIL masked_acc%0d: got %0d want -12", i, acc); end
    end
    tick();
    checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL masked_end: got %b want 0", accValid); end
  endtask

  task automatic test_clear_flush();
    doClear();
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    tick();
    applyStimulus(1'b1, 4'b0111, 4'b0011);
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    tick();
    tick();
    checks++; if (acc !== 8'sd5) begin failures++; $display("[TB] FAIL flush_setup: got %0d want 5", acc); end
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (acc !== 8'sd0) begin failures++; $display("[TB] FAIL flush_acc: got %0d want 0", acc); end
    checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid: got %b want 0", accValid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
    // A beat presented together with clear must also vanish.
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_drop_valid%0d: got %b want 0", i, accValid); end
      checks++; if (acc !== 8'sd0) begin failures++; $display("[TB] FAIL flush_drop_acc%0d: got %0d want 0", i, acc); end
    end
  endtask

  task automatic test_overflow();
    logic signed [7:0] expPeak;
    logic signed [7:0] expAfter;
    logic              expSat;
`ifdef BUNDLE_SAT_EN
    expPeak  = 8'sd127;
    expAfter = 8'sd123;
    expSat   = 1'b1;
`else
    expPeak  = 8'sh80;
    expAfter = 8'sd124;
    expSat   = 1'b0;
`endif
    doClear();
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    for (int i = 0; i < 32; i++) tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    tick();
    checks++; if (acc !== 8'sd124) begin failures++; $display("[TB] FAIL ovf_pre: got %0d want 124", acc); end
    checks++; if (sat !== 1'b0) begin failures++; $display("[TB] FAIL ovf_pre_sat: got %b want 0", sat); end
    tick();
    checks++; if (acc !== expPeak) begin failures++; $display("[TB] FAIL ovf_acc: got %0d want %0d", acc, expPeak); end
    checks++; if (sat !== expSat) begin failures++; $display("[TB] FAIL ovf_sat: got %b want %b", sat, expSat); end
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    tick();
    tick();
    checks++; if (acc !== expAfter) begin failures++; $display("[TB] FAIL ovf_after: got %0d want %0d", acc, expAfter); end
    checks++; if (sat !== expSat) begin failures++; $display("[TB] FAIL ovf_sticky: got %b want %b", sat, expSat); end
    doClear();
    checks++; if (sat !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear_sat: got %b want 0", sat); end
    checks++; if (acc !== 8'sd0) begin failures++; $display("[TB] FAIL ovf_clear_acc: got %0d want 0", acc); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    tick();
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (acc !== 8'sd0) begin failures++; $display("[TB] FAIL rstmid_acc: got %0d want 0", acc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid: got %b want 0", accValid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (accValid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_drop%0d: got %b want 0", i, accValid); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear    = 1'b0;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_masked();
    test_clear_flush();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
